// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: hunts for a frame sync, assembles WORD_W-bit
// words per time slot, and presents them through a one-entry valid/ready buffer.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [WORD_W-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic                      frame_err,
    output logic                      in_frame
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int BC_W = $clog2(WORD_W);

    typedef enum logic {
        ST_HUNT,
        ST_RECV
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [BC_W-1:0]     w_bit_nx;
    logic [CH_W-1:0]     r_ch_cnt;
    logic [CH_W-1:0]     w_ch_nx;
    logic [WORD_W-2:0]   r_word;
    logic [WORD_W-2:0]   w_word_nx;
    logic [WORD_W-1:0]   w_shift;
    logic                w_complete;
    logic                w_resync;
    logic                w_load;
    logic                w_drop;

    logic [WORD_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_out_valid;
    logic                r_overflow;
    logic                r_frame_err;

    // Only the WORD_W-1 earlier bits are stored; the completing bit comes from din.
    assign w_shift = {r_word, din};

    always_comb begin
        w_state_nx = r_state;
        w_bit_nx   = r_bit_cnt;
        w_ch_nx    = r_ch_cnt;
        w_word_nx  = r_word;
        w_complete = 1'b0;
        w_resync   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (din_valid && sync) begin
                    w_word_nx  = w_shift[WORD_W-2:0];
                    w_bit_nx   = BC_W'(1);
                    w_ch_nx    = '0;
                    w_state_nx = ST_RECV;
                end
            end
            ST_RECV: begin
                if (din_valid) begin
                    w_word_nx = w_shift[WORD_W-2:0];
                    if (sync) begin
                        // Resync takes priority, even over the final bit of a frame.
                        w_resync = 1'b1;
                        w_bit_nx = BC_W'(1);
                        w_ch_nx  = '0;
                    end else if (r_bit_cnt == BC_W'(WORD_W - 1)) begin
                        w_complete = 1'b1;
                        w_bit_nx   = '0;
                        if (r_ch_cnt == CH_W'(NUM_CH - 1)) begin
                            w_ch_nx    = '0;
                            w_state_nx = ST_HUNT;
                        end else begin
                            w_ch_nx = r_ch_cnt + CH_W'(1);
                        end
                    end else begin
                        w_bit_nx = r_bit_cnt + BC_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
            r_word    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_nx;
            r_ch_cnt  <= w_ch_nx;
            r_word    <= w_word_nx;
        end
    end

    // A buffer being drained this cycle can accept the next word without a bubble.
    assign w_load = w_complete && (!r_out_valid || out_ready);
    assign w_drop = w_complete && r_out_valid && !out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data  <= w_shift;
                r_out_ch    <= r_ch_cnt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_overflow  <= r_overflow | w_drop;
            r_frame_err <= w_resync;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign in_frame  = (r_state == ST_RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: 4x8 instance for framing/buffer scenarios,
// 2x2 instance for the back-to-back short-word case.
module tb_tdm_demux;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       din, din_valid, sync, out_ready;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid, overflow, frame_err, in_frame;

    logic       s_din, s_din_valid, s_sync, s_out_ready;
    logic [1:0] s_out_data;
    logic [0:0] s_out_ch;
    logic       s_out_valid, s_overflow, s_frame_err, s_in_frame;

    tdm_demux #(.NUM_CH(4), .WORD_W(8)) u_dut (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .frame_err(frame_err), .in_frame(in_frame)
    );

    tdm_demux #(.NUM_CH(2), .WORD_W(2)) u_dut2 (
        .clock(clock), .reset(reset), .din(s_din), .din_valid(s_din_valid), .sync(s_sync),
        .out_data(s_out_data), .out_ch(s_out_ch), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .overflow(s_overflow), .frame_err(s_frame_err), .in_frame(s_in_frame)
    );

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [2:0] got2_q[$];
    int         err_pulses = 0;
    int         checks = 0;
    int         errors = 0;
    int         pulses_before;

    // Transfer and pulse recorder; all judging happens in the stimulus block.
    always @(posedge clock) begin
        if (out_valid && out_ready)     got_q.push_back({out_ch, out_data});
        if (s_out_valid && s_out_ready) got2_q.push_back({s_out_ch, s_out_data});
        if (frame_err)                  err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic s);
        @(negedge clock);
        din_valid = v;
        din       = d;
        sync      = s;
    endtask

    task automatic s_drive(input logic v, input logic d, input logic s);
        @(negedge clock);
        s_din_valid = v;
        s_din       = d;
        s_sync      = s;
    endtask

    task automatic send_word(input logic [7:0] w, input logic first_sync, input logic gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'($urandom));
            drive(1'b1, w[7-i], first_sync && (i == 0));
        end
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3, input logic gaps);
        send_word(w0, 1'b1, gaps);
        send_word(w1, 1'b0, gaps);
        send_word(w2, 1'b0, gaps);
        send_word(w3, 1'b0, gaps);
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_basic();
        exp_q.push_back({2'd0, 8'hA5});
        exp_q.push_back({2'd1, 8'h3C});
        exp_q.push_back({2'd2, 8'hFF});
        exp_q.push_back({2'd3, 8'h01});
    endtask

    initial begin
        reset = 1'b1;
        din = 1'b0; din_valid = 1'b0; sync = 1'b0; out_ready = 1'b1;
        s_din = 1'b0; s_din_valid = 1'b0; s_sync = 1'b0; s_out_ready = 1'b1;

        // Reset state
        @(posedge clock); #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_in_frame",  32'(in_frame),  32'd0);
        chk("rst2_flags", 32'({s_out_valid, s_overflow, s_frame_err, s_in_frame}), 32'd0);
        @(negedge clock) reset = 1'b0;

        // Basic frame with latency checks
        pulses_before = err_pulses;
        send_word(8'hA5, 1'b1, 1'b0);
        chk("lat_before", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data",  32'(out_data),  32'hA5);
        chk("lat_ch",    32'(out_ch),    32'd0);
        chk("mid_in_frame", 32'(in_frame), 32'd1);
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        send_word(8'h01, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk("end_in_frame", 32'(in_frame), 32'd0);
        chk("end_data", 32'(out_data), 32'h01);
        chk("end_ch",   32'(out_ch),   32'd3);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        push_basic();
        check_q("basic");
        chk("basic_overflow", 32'(overflow), 32'd0);
        chk("basic_no_err", 32'(err_pulses - pulses_before), 32'd0);

        // Hunt: unsynced bits ignored; gapped frame decodes identically
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("hunt_in_frame", 32'(in_frame), 32'd0);
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        push_basic();
        check_q("gaps");

        // Resync at bit 13 (ch1 bit 4), followed by a full frame
        pulses_before = err_pulses;
        send_word(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("resync_pulses", 32'(err_pulses - pulses_before), 32'd1);
        exp_q.push_back({2'd0, 8'hA5});
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd1, 8'h22});
        exp_q.push_back({2'd2, 8'h33});
        exp_q.push_back({2'd3, 8'h44});
        check_q("resync");

        // Backpressure: first word held, the rest dropped, overflow sticky
        out_ready = 1'b0;
        send_word(8'hA5, 1'b1, 1'b0);
        @(posedge clock); #1;
        chk("bp_first_no_ovf", 32'(overflow), 32'd0);
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        send_word(8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data",  32'(out_data),  32'hA5);
        chk("bp_hold_ch",    32'(out_ch),    32'd0);
        chk("bp_overflow",   32'(overflow),  32'd1);
        chk("bp_no_xfer",    32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        chk("bp_ovf_sticky", 32'(overflow),  32'd1);
        chk("bp_drained",    32'(out_valid), 32'd0);
        exp_q.push_back({2'd0, 8'hA5});
        check_q("bp");

        // Reset mid-frame with a held word
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b0;
        send_word(8'hA5, 1'b1, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b1, 1'b0);
        @(posedge clock); #2;
        chk("pre_rst_valid",    32'(out_valid), 32'd1);
        chk("pre_rst_overflow", 32'(overflow),  32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_outs",
            32'({out_valid, overflow, frame_err, in_frame, out_ch, out_data}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        din_valid = 1'b0;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        push_basic();
        check_q("post_rst");
        chk("post_rst_overflow", 32'(overflow), 32'd0);

        // 2x2 instance: two back-to-back frames of 10,01
        for (int f = 0; f < 2; f++) begin
            s_drive(1'b1, 1'b1, 1'b1);
            s_drive(1'b1, 1'b0, 1'b0);
            s_drive(1'b1, 1'b0, 1'b0);
            s_drive(1'b1, 1'b1, 1'b0);
        end
        repeat (3) s_drive(1'b0, 1'b0, 1'b0);
        chk("w2_count", 32'(got2_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("w2_word%0d", i),
                (i < got2_q.size()) ? 32'(got2_q[i]) : 32'hDEAD_BEEF,
                (i % 2 == 0) ? 32'h2 : 32'h5);
        chk("w2_overflow", 32'(s_overflow), 32'd0);
        chk("w2_frame_err", 32'({s_frame_err, s_in_frame}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
